// File: rtl/mgpio_pkg.sv
// mgpio_pkg: shared types and limits for the mgpio GPIO bank.
//   mgpio_op_t      encoding of the data_op field (write/set/clear/toggle)
//   MGPIO_MAX_SYNC  deepest input synchroniser the bank supports
package mgpio_pkg;

  typedef enum logic [1:0] {
    MGPIO_OP_WRITE  = 2'b00,
    MGPIO_OP_SET    = 2'b01,
    MGPIO_OP_CLEAR  = 2'b10,
    MGPIO_OP_TOGGLE = 2'b11
  } mgpio_op_t;

  localparam int MGPIO_MAX_SYNC = 4;

endpackage

// File: rtl/mgpio_sync.sv
// mgpio_sync: multi-stage flop synchroniser for asynchronous pad inputs.
//   clk    clock
//   rst    synchronous active-low reset, clears every stage
//   d      raw input vector
//   q      synchronised output (last stage), or d itself when STAGES=0
module mgpio_sync
  import mgpio_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Depth is clamped so an out-of-range parameter cannot build a longer chain.
  localparam int NSTAGES = (STAGES > MGPIO_MAX_SYNC) ? MGPIO_MAX_SYNC : STAGES;

  generate
    if (NSTAGES == 0) begin : g_wire
      assign q = d;
    end else begin : g_flops
      logic [WIDTH-1:0] sync_q [NSTAGES];
      logic [WIDTH-1:0] sync_d [NSTAGES];

      always_comb begin
        sync_d[0] = d;
        for (int i = 1; i < NSTAGES; i++) begin
          sync_d[i] = sync_q[i-1];
        end
      end

      always_ff @(posedge clk) begin
        if (!rst) begin
          for (int i = 0; i < NSTAGES; i++) begin
            sync_q[i] <= '0;
          end
        end else begin
          for (int i = 0; i < NSTAGES; i++) begin
            sync_q[i] <= sync_d[i];
          end
        end
      end

      assign q = sync_q[NSTAGES-1];
    end
  endgenerate

endmodule

// File: rtl/mgpio_bank_irq.sv
// mgpio_bank_irq: GPIO bank with per-bit direction, atomic data updates,
// input synchroniser, rising/falling edge detection, sticky W1C pending
// register and a single level interrupt.
//   clk, rst                      clock, synchronous active-low reset
//   data_en/data_op/data_in       write/set/clear/toggle of the data register
//   dir_en/dir_in                 direction load (1 = output)
//   rise_en/rise_in, fall_en/fall_in  edge mask loads
//   pend_clr_en/pend_clr          write-1-to-clear of pending bits
//   data_out/dir_out/rise_out/fall_out/pend_out  register readback
//   irq                           OR of pending bits
//   gpio_in/gpio_out/gpio_oe      pad interface
module mgpio_bank_irq
  import mgpio_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             data_en,
  input  logic [1:0]       data_op,
  input  logic [WIDTH-1:0] data_in,
  input  logic             dir_en,
  input  logic [WIDTH-1:0] dir_in,
  input  logic             rise_en,
  input  logic [WIDTH-1:0] rise_in,
  input  logic             fall_en,
  input  logic [WIDTH-1:0] fall_in,
  input  logic             pend_clr_en,
  input  logic [WIDTH-1:0] pend_clr,
  output logic [WIDTH-1:0] data_out,
  output logic [WIDTH-1:0] dir_out,
  output logic [WIDTH-1:0] rise_out,
  output logic [WIDTH-1:0] fall_out,
  output logic [WIDTH-1:0] pend_out,
  output logic             irq,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_out,
  output logic [WIDTH-1:0] gpio_oe
);

  logic [WIDTH-1:0] pin_s;
  logic [WIDTH-1:0] op_res;
  logic [WIDTH-1:0] ev;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] dir_q,  dir_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic [WIDTH-1:0] prev_q, prev_d;

  mgpio_sync #(
    .WIDTH  (WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (gpio_in),
    .q   (pin_s)
  );

  // Input bits always reload from the pin, so a bit turned into an output
  // starts driving its last sampled value. All masking uses the old dir.
  always_comb begin
    op_res = data_q;
    if (data_en) begin
      case (mgpio_op_t'(data_op))
        MGPIO_OP_WRITE:  op_res = data_in;
        MGPIO_OP_SET:    op_res = data_q | data_in;
        MGPIO_OP_CLEAR:  op_res = data_q & ~data_in;
        MGPIO_OP_TOGGLE: op_res = data_q ^ data_in;
        default:         op_res = data_q;
      endcase
    end
    data_d = (op_res & dir_q) | (pin_s & ~dir_q);

    dir_d  = dir_en  ? dir_in  : dir_q;
    rise_d = rise_en ? rise_in : rise_q;
    fall_d = fall_en ? fall_in : fall_q;
    prev_d = pin_s;

    // New events are OR'd in after the clear so a coincident event survives.
    ev     = ~dir_q & ((pin_s & ~prev_q & rise_q) | (~pin_s & prev_q & fall_q));
    pend_d = (pend_q & ~(pend_clr_en ? pend_clr : '0)) | ev;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      data_q <= '0;
      dir_q  <= '0;
      rise_q <= '0;
      fall_q <= '0;
      pend_q <= '0;
      prev_q <= '0;
    end else begin
      data_q <= data_d;
      dir_q  <= dir_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      pend_q <= pend_d;
      prev_q <= prev_d;
    end
  end

  assign data_out = data_q;
  assign dir_out  = dir_q;
  assign rise_out = rise_q;
  assign fall_out = fall_q;
  assign pend_out = pend_q;
  assign irq      = |pend_q;
  assign gpio_out = data_q;
  assign gpio_oe  = dir_q;

endmodule

// File: doc/mgpio_bank_irq.md
Name: mgpio_bank_irq

Overview:
Parametrised next-generation GPIO bank: WIDTH pins with per-bit direction, output data register and atomic set/clear/toggle updates. Adds a configurable input synchroniser, per-bit rising/falling edge detection and a sticky pending register with write-1-to-clear. Drives a single level interrupt. Sits between the bus register slave, which decodes accesses into the strobes below, and the pad ring.

Parameters:
WIDTH, 8, number of pins in the bank; legal range 1..32.
SYNC_STAGES, 2, flop stages on gpio_in; legal range 0..4; 0 = no synchroniser, pin value used directly.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-low
data_en  in  1  apply data_op with data_in this cycle
data_op  in  2  00 write, 01 set, 10 clear, 11 toggle
data_in  in  WIDTH  operand for data_op
dir_en  in  1  load dir_in into dir
dir_in  in  WIDTH  1 = output, 0 = input
rise_en  in  1  load rise_in into rise mask
rise_in  in  WIDTH  per-bit rising-edge enable
fall_en  in  1  load fall_in into fall mask
fall_in  in  WIDTH  per-bit falling-edge enable
pend_clr_en  in  1  apply pend_clr
pend_clr  in  WIDTH  write-1-to-clear pending bits
data_out  out  WIDTH  data register: driven value on outputs, synchronised pin value on inputs
dir_out  out  WIDTH  dir register
rise_out  out  WIDTH  rise mask
fall_out  out  WIDTH  fall mask
pend_out  out  WIDTH  pending register
irq  out  1  OR of pend
gpio_in  in  WIDTH  pad input
gpio_out  out  WIDTH  = data
gpio_oe  out  WIDTH  = dir

Behaviour:
- Reset (rst==0 at a clk edge):
  - data, dir, rise, fall, pend, sync chain and prev all become 0.
  - Result: all outputs 0 and irq 0. Data resets to 0, never X.
- pin_s is the last sync stage, or gpio_in when SYNC_STAGES=0.
- prev <= pin_s every cycle.
- Data update every cycle:
  - op_res = data_in (write), data|data_in (set), data&~data_in (clear), data^data_in (toggle).
  - op_res = data when data_en=0.
  - nxt_data = (op_res & dir) | (pin_s & ~dir), using the current, pre-update dir.
- Latency: a gpio_in change first appears on data_out SYNC_STAGES+1 edges later.
- Simultaneous dir_en and data_en: data uses the old dir; the new dir takes effect from the next cycle.
  - A bit switching from input to output drives its last sampled pin value, so there is no glitch.
  - A data_en write to a bit that is still an input is discarded.
- Edge events, only on bits with dir=0 at detection time:
  - rise_ev = pin_s & ~prev & rise
  - fall_ev = ~pin_s & prev & fall
  - ev = rise_ev | fall_ev
- Pending: pend <= (pend & ~(pend_clr_en ? pend_clr : 0)) | ev.
  - Set wins over clear in the same cycle.
- Pending timing: a pin edge sets pend SYNC_STAGES+1 edges after the gpio_in change. irq = |pend, combinational from the register, so it carries no extra delay.
- rise/fall/dir loads take effect for detection from the next cycle.
  - Enabling a mask never creates a retroactive event.
  - Disabling a mask does not clear already-pending bits.
- Bits with dir=1 never set pend. Pending bits survive a direction change until cleared.
- Reset mid-operation: all state returns to 0 on the same edge; in-flight sync samples are discarded.

Decomposition:
- Package mgpio_pkg:
  - typedef enum logic [1:0] mgpio_op_t { MGPIO_OP_WRITE, MGPIO_OP_SET, MGPIO_OP_CLEAR, MGPIO_OP_TOGGLE }.
  - Localparam MGPIO_MAX_SYNC = 4.
- Sub-module mgpio_sync:
  - Parameters WIDTH and STAGES; ports clk, rst, d, q.
  - STAGES=0 is a wire.
  - Instantiated once for gpio_in.
- Everything else, including edge detect and the pending register, lives in mgpio_bank_irq.

Test Plan:
- Reset, then dir_en with dir_in=8'h0F, then data_en op=WRITE data_in=8'hA5 -> gpio_oe=8'h0F, gpio_out[3:0]=4'h5, irq=0.
- Outputs 8'h0F, data=8'h05; op SET 8'h0A -> data[3:0]=4'hF; op CLEAR 8'h03 -> 4'hC; op TOGGLE 8'hFF -> 4'h3, with input bits tracking gpio_in.
- SYNC_STAGES=2, dir=0, rise=8'h01; gpio_in[0] rises at edge k -> data_out[0]=1 at k+3, pend=8'h01 and irq=1 at k+3; gpio_in[0] falls -> no new event (fall=0).
- Pending bit 0 set, pend_clr_en with 8'h01 in the same cycle a new bit-0 event arrives -> pend[0] stays 1; clear alone next -> pend=0, irq=0.
- Input bit 4 reads 1; in one cycle dir_en dir_in=8'h10 plus data_en WRITE 8'h00 -> write to bit 4 is discarded, gpio_out[4]=1 with no glitch; next WRITE 8'h00 -> gpio_out[4]=0; edges on gpio_in[4] do not set pend.
- rst=0 mid-traffic with pend=8'hFF, dir=8'hF0 -> next edge: all outputs 0; SYNC_STAGES=0 build -> data_out follows gpio_in after 1 edge.
